// File: rtl/prog_loader.sv
// Program memory loader: assembles a COUNT/words/CSUM byte frame into 16-bit
// word writes at consecutive addresses and holds the CPU in reset until a load verifies.
module prog_loader #(
  parameter int PC_WIDTH  = 8,
  parameter int DataWidth = 16
) (
  input  logic                 clk,
  input  logic                 res_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  output logic                 wr_en,
  output logic [PC_WIDTH-1:0]  wr_addr,
  output logic [DataWidth-1:0] wr_data,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 cpu_res_n
);

  typedef enum logic [2:0] {IDLE, COUNT, HI, LO, WRITE, CSUM, DONE} state_t;

  state_t      state;
  logic [7:0]  count_n;
  logic [7:0]  hi_byte;
  logic [7:0]  sum;
  logic [8:0]  idx;
  logic [8:0]  idx_next;
  logic [8:0]  target;
  logic        xfer;

  function automatic logic [7:0] add_mod256(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

  assign xfer     = byte_valid & byte_ready;
  assign idx_next = idx + 9'd1;
  // A COUNT byte of zero stands for a full memory of 2^PC_WIDTH words.
  assign target   = (count_n == 8'd0) ? 9'(1 << PC_WIDTH) : {1'b0, count_n};

  always_ff @(posedge clk) begin
    if (!res_n) begin
      state      <= IDLE;
      byte_ready <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      cpu_res_n  <= 1'b0;
      count_n    <= 8'd0;
      hi_byte    <= 8'd0;
      sum        <= 8'd0;
      idx        <= 9'd0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      // Abort beats everything outside IDLE; a write already on the bus this cycle still lands.
      if (abort && state != IDLE) begin
        state      <= IDLE;
        err        <= 1'b1;
        busy       <= 1'b0;
        byte_ready <= 1'b0;
        cpu_res_n  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              state      <= COUNT;
              busy       <= 1'b1;
              err        <= 1'b0;
              idx        <= 9'd0;
              sum        <= 8'd0;
              byte_ready <= 1'b1;
              cpu_res_n  <= 1'b0;
            end
          end
          COUNT: begin
            if (xfer) begin
              count_n <= byte_in;
              state   <= HI;
            end
          end
          HI: begin
            if (xfer) begin
              hi_byte <= byte_in;
              sum     <= add_mod256(sum, byte_in);
              state   <= LO;
            end
          end
          LO: begin
            if (xfer) begin
              sum        <= add_mod256(sum, byte_in);
              wr_en      <= 1'b1;
              wr_addr    <= idx[PC_WIDTH-1:0];
              wr_data    <= {hi_byte, byte_in};
              byte_ready <= 1'b0;
              state      <= WRITE;
            end
          end
          WRITE: begin
            idx        <= idx_next;
            byte_ready <= 1'b1;
            state      <= (idx_next == target) ? CSUM : HI;
          end
          CSUM: begin
            if (xfer) begin
              byte_ready <= 1'b0;
              busy       <= 1'b0;
              if (byte_in == sum) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state <= IDLE;
                err   <= 1'b1;
              end
            end
          end
          DONE: begin
            state     <= IDLE;
            cpu_res_n <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table-driven frames, hand-written abort/reset sequences and
// random frames checked against a frame-level model of the expected writes and checksum.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        res_n;
  logic        start;
  logic        abort;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_res_n;

  always #5 clk = ~clk;

  prog_loader #(.PC_WIDTH(8), .DataWidth(16)) dut (
    .clk(clk), .res_n(res_n), .start(start), .abort(abort),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err), .cpu_res_n(cpu_res_n)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int          nwords;
    logic [15:0] w0;
    logic [15:0] w1;
    logic [15:0] w2;
    logic [7:0]  csum;
    int          pct;
    bit          exp_ok;
  } vec_t;

  typedef struct packed {
    logic [7:0]  a;
    logic [15:0] d;
  } wr_t;

  vec_t        tbl [5];
  logic [15:0] frame_w [256];
  wr_t         wq [$];
  int          done_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Write memory image and done pulses as seen by the program memory.
  always @(negedge clk) begin
    if (wr_en) begin
      wq.push_back({wr_addr, wr_data});
      chk("ready_in_write", 32'(byte_ready), 32'd0);
    end
    if (done) done_cnt++;
  end

  function automatic logic [7:0] model_sum(input int nw);
    int s = 0;
    for (int i = 0; i < nw; i++) s += frame_w[i][15:8] + frame_w[i][7:0];
    return 8'(s % 256);
  endfunction

  task automatic send_byte(input logic [7:0] b, input int pct);
    bit sent = 0;
    int guard = 0;
    while (!sent) begin
      @(negedge clk);
      byte_in    = b;
      byte_valid = ($urandom_range(99) < pct);
      sent       = byte_valid && byte_ready;
      @(posedge clk);
      guard++;
      if (!sent && guard > 300) begin
        chk("byte_timeout", 32'd0, 32'd1);
        sent = 1;
      end
    end
    #1 byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic check_writes(input int nw);
    int bi = -1;
    int bound;
    logic [7:0] ae;
    chk("write_count", 32'(wq.size()), 32'(nw));
    bound = (wq.size() < nw) ? wq.size() : nw;
    for (int i = 0; i < bound; i++) begin
      ae = 8'(i % 256);
      if (bi < 0 && (wq[i].a !== ae || wq[i].d !== frame_w[i])) bi = i;
    end
    if (bi < 0) bi = bound - 1;
    if (bi >= 0) begin
      ae = 8'(bi % 256);
      chk("write_content", 32'({wq[bi].a, wq[bi].d}), 32'({ae, frame_w[bi]}));
    end
  endtask

  task automatic run_frame(input int nw, input logic [7:0] csum, input int pct,
                           input bit exp_ok, input bit mid_start);
    logic [7:0] nb;
    int d0;
    nb = (nw == 256) ? 8'd0 : 8'(nw);
    d0 = done_cnt;
    wq.delete();
    pulse_start();
    chk("busy_on_start", 32'(busy), 32'd1);
    chk("cpu_held_on_start", 32'(cpu_res_n), 32'd0);
    send_byte(nb, pct);
    for (int i = 0; i < nw; i++) begin
      send_byte(frame_w[i][15:8], pct);
      send_byte(frame_w[i][7:0], pct);
      if (mid_start && i == 0) pulse_start();
    end
    send_byte(csum, pct);
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'(exp_ok));
    chk("err_flag", 32'(err), 32'(!exp_ok));
    chk("busy_end", 32'(busy), 32'd0);
    @(negedge clk);
    chk("cpu_res_n_after", 32'(cpu_res_n), 32'(exp_ok));
    chk("done_count", 32'(done_cnt - d0), 32'(exp_ok));
    check_writes(nw);
  endtask

  initial begin
    int nw;
    bit corrupt;
    logic [7:0] cs;

    tbl[0] = '{3, 16'h4903, 16'h4A14, 16'h4BF0, 8'hE5, 100, 1'b1};
    tbl[1] = '{3, 16'h4903, 16'h4A14, 16'h4BF0, 8'h00, 100, 1'b0};
    tbl[2] = '{3, 16'h4903, 16'h4A14, 16'h4BF0, 8'hE5, 100, 1'b1};
    tbl[3] = '{2, 16'h8802, 16'h0000, 16'h0000, 8'h8A, 50, 1'b1};
    tbl[4] = '{1, 16'h1234, 16'h0000, 16'h0000, 8'h46, 70, 1'b1};

    res_n = 1'b0; start = 1'b0; abort = 1'b0; byte_in = 8'd0; byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({byte_ready, wr_en, wr_addr, wr_data, busy, done, err, cpu_res_n}), 32'd0);
    res_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_cpu_held", 32'(cpu_res_n), 32'd0);

    for (int t = 0; t < 5; t++) begin
      frame_w[0] = tbl[t].w0;
      frame_w[1] = tbl[t].w1;
      frame_w[2] = tbl[t].w2;
      run_frame(tbl[t].nwords, tbl[t].csum, tbl[t].pct, tbl[t].exp_ok, 1'b0);
    end

    // start and abort together in IDLE: nothing happens.
    @(negedge clk) begin start = 1'b1; abort = 1'b1; end
    @(negedge clk) begin start = 1'b0; abort = 1'b0; end
    chk("idle_abort_busy", 32'({busy, err, cpu_res_n, byte_ready}), 32'b0010);

    // start while busy must not restart the load.
    frame_w[0] = 16'hA1B2; frame_w[1] = 16'hC3D4;
    run_frame(2, model_sum(2), 100, 1'b1, 1'b1);

    // abort after the high byte of word 1.
    frame_w[0] = 16'h1111; frame_w[1] = 16'h2222;
    wq.delete();
    pulse_start();
    send_byte(8'd3, 100);
    send_byte(8'h11, 100);
    send_byte(8'h11, 100);
    send_byte(8'h22, 100);
    @(negedge clk) abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    chk("abort_state", 32'({err, busy, byte_ready, cpu_res_n}), 32'b1000);
    repeat (5) @(negedge clk);
    check_writes(1);

    for (int r = 0; r < 6; r++) begin
      nw = $urandom_range(8, 1);
      for (int i = 0; i < nw; i++) frame_w[i] = 16'($urandom);
      corrupt = ($urandom_range(2) == 0);
      cs = model_sum(nw) + (corrupt ? 8'($urandom_range(255, 1)) : 8'd0);
      run_frame(nw, cs, $urandom_range(100, 30), !corrupt, 1'b0);
    end

    // reset pulse while waiting for the low byte.
    wq.delete();
    pulse_start();
    send_byte(8'd2, 100);
    send_byte(8'h77, 100);
    @(negedge clk) begin res_n = 1'b0; byte_valid = 1'b1; byte_in = 8'h55; end
    @(negedge clk);
    chk("midload_reset", 32'({byte_ready, wr_en, wr_addr, wr_data, busy, done, err, cpu_res_n}), 32'd0);
    res_n = 1'b1; byte_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset_no_write", 32'(wq.size()), 32'd0);
    chk("reset_idle", 32'({busy, byte_ready}), 32'd0);

    for (int i = 0; i < 256; i++) frame_w[i] = 16'h0101;
    run_frame(256, model_sum(256), 100, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the program memory: accepts a byte stream, assembles 16-bit instructions, and issues word writes into the program memory at consecutive addresses starting from 0.
- Holds the CPU in reset while a load is in progress.
- Verifies an 8-bit checksum and reports the result with done/err.
- Sits between the host byte link (UART/debug port) and the program memory write port.

Parameters:
PC_WIDTH, 8, program memory address width; must be ≤ 8.
DataWidth, 16, instruction width; fixed at 16 (two bytes per word).

Ports:
clk  in  1  system clock; all logic on rising edge
res_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse, begins a load
abort  in  1  abandons the current load
byte_in  in  8  stream byte
byte_valid  in  1  byte_in is valid
byte_ready  out  1  loader accepts a byte this cycle
wr_en  out  1  program memory write strobe, one cycle
wr_addr  out  PC_WIDTH  write address
wr_data  out  DataWidth  instruction word
busy  out  1  load in progress
done  out  1  one-cycle pulse, load succeeded
err  out  1  sticky error flag
cpu_res_n  out  1  CPU reset, active-low

Behaviour:
- Reset (res_n=0 at clk edge) forces:
  - state IDLE
  - byte_ready=0, wr_en=0, wr_addr=0, wr_data=0
  - busy=0, done=0, err=0, cpu_res_n=0
- Output qualification:
  - cpu_res_n = 1 only when not in reset, not busy, and err=0. It is registered and deasserts in the same cycle busy rises.
  - A byte transfer occurs on a clk edge with byte_valid=1 and byte_ready=1.
  - byte_ready is a registered function of state: 1 in COUNT, HI, LO, CSUM; 0 elsewhere.
- Frame format: COUNT byte N, then N words (high byte first), then CSUM byte.
  - N=0 means 2^PC_WIDTH words.
  - Checksum = mod-256 sum of all data bytes, excluding the COUNT byte.
- State machine:
  - IDLE: start=1 → COUNT. On entry: busy=1, err=0, word index=0, running sum=0. start is ignored in every other state.
  - COUNT: on transfer, latch N → HI.
  - HI: on transfer, latch the high byte, add it to the sum → LO.
  - LO: on transfer, latch the low byte, add it to the sum → WRITE.
  - WRITE (exactly 1 cycle):
    - Assert wr_en=1 with wr_addr = word index truncated to PC_WIDTH and wr_data = {hi,lo}.
    - Increment the word index.
    - If the word count reaches N → CSUM, else → HI.
  - CSUM: on transfer, compare the byte with the sum.
    - Equal → DONE.
    - Not equal → IDLE with err=1, busy=0; cpu_res_n stays 0.
  - DONE (1 cycle): done=1, busy=0 → IDLE; cpu_res_n=1 from the next cycle.
- Latency:
  - Low byte accepted at edge k → wr_en high during cycle k+1.
  - Back-to-back words need at least 3 cycles (HI, LO, WRITE).
- Word index counts 0..N-1 and is 9 bits wide, so N=0 with PC_WIDTH=8 counts to 256. wr_addr wraps naturally.
- byte_valid held high with no stall is accepted every ready cycle. Gaps in byte_valid simply stall the FSM.
- abort=1 in any non-IDLE state → IDLE with err=1, busy=0, no further wr_en. A write in progress (WRITE state) still completes that cycle. abort in IDLE has no effect.
- start and abort both high in IDLE: abort wins and the FSM stays IDLE. err is not set.
- Reset mid-load: immediate return to reset values; no wr_en in the following cycle.
- Memory contents written before an error or abort are not rolled back.

Test Plan:
- Reset then load N=3 with bytes 49 03 4A 14 4B F0 and CSUM E5 → three wr_en pulses:
  - (0,4903), (1,4A14), (2,4BF0)
  - then done pulse, err=0, cpu_res_n=1 afterwards
  - verify by reading back via the Program_Mem pc/ir interface.
- Same stream with CSUM 00 → three writes occur, no done pulse, err=1, cpu_res_n stays 0. A subsequent correct load clears err and releases cpu_res_n.
- Toggle byte_valid randomly (50%) during the N=2 load 88 02 00 00, CSUM 8A → identical writes (0,8802), (1,0000). byte_ready drops during each WRITE cycle; no byte is lost or duplicated.
- N=0 with 512 bytes of value 01 and CSUM 00 → 256 writes of 0101 to addresses 0..255, last address FF, done=1.
- abort after the high byte of word 1 → no write for word 1, err=1, busy=0. start pulses issued while busy are ignored (no restart, index not cleared).
- Drive res_n=0 for one cycle while in LO → all outputs at reset values the next cycle, no wr_en, FSM in IDLE.
